fetch_stage: RTL and testbench

- Instruction fetch stage of the rv32i core. Sits directly upstream of the instruction memory: drives its byte-address PC and captures the 32-bit word it returns combinationally.
- Buffers fetched {pc, instr} pairs in a small FIFO toward decode, using a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing the FIFO and reloading the PC.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 88 ++++++++
 tb/tb_fetch_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory address/data, redirect request and the decode-facing valid/ready stream.
// The master side (fetch_stage) drives im_pc and the out_* stream; the slave side drives the rest.
interface fetch_stage_if #(
    parameter int unsigned PC_WIDTH = 16
);
    logic [PC_WIDTH-1:0] im_pc;
    logic [31:0]         im_instr;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_instr;
    logic [PC_WIDTH-1:0] out_pc;
    logic [PC_WIDTH-1:0] out_pc_plus4;

    modport master (
        output im_pc, out_valid, out_instr, out_pc, out_pc_plus4,
        input  im_instr, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  im_pc, out_valid, out_instr, out_pc, out_pc_plus4,
        output im_instr, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// rv32i fetch: drives the IM PC, queues {pc, instr} in a DEPTH-entry FIFO toward decode, flushes on redirect.
// One edge from fetch to head; fetch PC stalls only when the FIFO is full and the head is not popped.
module fetch_stage #(
    parameter int unsigned         PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned         DEPTH    = 2
) (
    input logic           clk,
    input logic           rst,
    fetch_stage_if.master bus
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   NOP      = 32'h00000013;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [PC_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [31:0]         instr_mem_q [DEPTH];
    logic                head_vld, push, pop;

    assign head_vld = (count_q != '0);
    assign pop      = head_vld & bus.out_ready;
    assign push     = ~bus.redirect_valid & ((count_q < FULL_CNT) | pop);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (bus.redirect_valid) begin
            // A same-cycle pop is still seen by decode; the flush drops it regardless.
            fetch_pc_d = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
                wr_ptr_d   = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: every output is masked by head_vld.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= bus.im_instr;
        end
    end

    assign bus.im_pc        = fetch_pc_q;
    assign bus.out_valid    = head_vld;
    assign bus.out_instr    = head_vld ? instr_mem_q[rd_ptr_q] : NOP;
    assign bus.out_pc       = head_vld ? pc_mem_q[rd_ptr_q] : '0;
    assign bus.out_pc_plus4 = head_vld ? pc_mem_q[rd_ptr_q] + PC_WIDTH'(4) : '0;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written wrap/async-reset sequences, then random traffic vs a queue model.
module tb_fetch_stage;
    localparam int unsigned PCW    = 16;
    localparam int unsigned DEPTH  = 2;
    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    fetch_stage_if #(.PC_WIDTH(PCW)) bus ();

    fetch_stage #(.PC_WIDTH(PCW), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [15:0] pc);
        case (pc)
            16'h0000: return 32'h00300413;
            16'h0004: return 32'h00100493;
            16'h0008: return 32'h01000913;
            default:  return {pc ^ 16'hC3C3, pc};
        endcase
    endfunction

    assign bus.im_instr = word(bus.im_pc);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs derived from the head entry's pc alone.
    task automatic check_out(input string tag, input logic ev, input logic [15:0] epc, input logic [15:0] eimpc);
        chk({tag, " out_valid"}, {31'b0, bus.out_valid}, {31'b0, ev});
        chk({tag, " out_pc"}, {16'b0, bus.out_pc}, ev ? {16'b0, epc} : 32'h0);
        chk({tag, " out_instr"}, bus.out_instr, ev ? word(epc) : NOP);
        chk({tag, " out_pc_plus4"}, {16'b0, bus.out_pc_plus4}, ev ? {16'b0, 16'(epc + 16'd4)} : 32'h0);
        chk({tag, " im_pc"}, {16'b0, bus.im_pc}, {16'b0, eimpc});
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [15:0] rpc);
        bus.out_ready      = rdy;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    // Reference model: queue of buffered pcs plus the fetch pc.
    logic [15:0] mq[$];
    logic [15:0] mfpc;

    task automatic model_cycle(input string tag, input logic rdy, input logic rv, input logic [15:0] rpc);
        logic ev, pop, push;
        drive(rdy, rv, rpc);
        ev = (mq.size() != 0);
        check_out(tag, ev, ev ? mq[0] : 16'h0, mfpc);
        pop  = ev && rdy;
        push = !rv && ((mq.size() < DEPTH) || pop);
        if (rv) begin
            mq.delete();
            mfpc = rpc & 16'hFFFC;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(mfpc);
                mfpc = mfpc + 16'd4;
            end
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [15:0] rpc;
        logic        ev;
        logic [15:0] epc;
        logic [15:0] eimpc;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(input logic rdy, input logic rv, input logic [15:0] rpc,
                                input logic ev, input logic [15:0] epc, input logic [15:0] eimpc);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc; v.eimpc = eimpc;
        return v;
    endfunction

    initial begin
        // Each row: inputs applied at a negedge, outputs expected at that same negedge.
        vt[0]  = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000); // reset state
        vt[1]  = mk(1, 0, 16'h0000, 1, 16'h0000, 16'h0004); // first valid 1 edge after release
        vt[2]  = mk(1, 0, 16'h0000, 1, 16'h0004, 16'h0008);
        vt[3]  = mk(0, 0, 16'h0000, 1, 16'h0008, 16'h000C);
        vt[4]  = mk(0, 0, 16'h0000, 1, 16'h0008, 16'h0010); // full
        vt[5]  = mk(0, 0, 16'h0000, 1, 16'h0008, 16'h0010); // stalled
        vt[6]  = mk(1, 0, 16'h0000, 1, 16'h0008, 16'h0010); // full + pop
        vt[7]  = mk(0, 0, 16'h0000, 1, 16'h000C, 16'h0014);
        vt[8]  = mk(1, 0, 16'h0000, 1, 16'h000C, 16'h0014);
        vt[9]  = mk(1, 1, 16'h0016, 1, 16'h0010, 16'h0018); // misaligned redirect at im_pc 24
        vt[10] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0014);
        vt[11] = mk(1, 0, 16'h0000, 1, 16'h0014, 16'h0018);
        vt[12] = mk(1, 0, 16'h0000, 1, 16'h0018, 16'h001C);

        drive(0, 0, 16'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive(vt[i].rdy, vt[i].rv, vt[i].rpc);
            check_out($sformatf("vec%0d", i), vt[i].ev, vt[i].epc, vt[i].eimpc);
            @(negedge clk);
        end

        // Wrap at the top of the address space.
        drive(1, 1, 16'hFFFE);
        @(negedge clk);
        drive(1, 0, 16'h0);
        check_out("wrap0", 1'b0, 16'h0000, 16'hFFFC);
        @(negedge clk);
        check_out("wrap1", 1'b1, 16'hFFFC, 16'h0000);
        chk("wrap plus4", {16'b0, bus.out_pc_plus4}, 32'h0000_0000);
        @(negedge clk);
        check_out("wrap2", 1'b1, 16'h0000, 16'h0004);

        // Fill the FIFO, then assert reset between edges.
        drive(0, 0, 16'h0);
        repeat (3) @(negedge clk);
        chk("prefill valid", {31'b0, bus.out_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_out("async rst", 1'b0, 16'h0000, RST_PC);
        @(negedge clk);
        check_out("rst held", 1'b0, 16'h0000, RST_PC);
        rst = 1'b0;
        mq.delete();
        mfpc = RST_PC;
        model_cycle("post rst0", 1'b1, 1'b0, 16'h0);
        model_cycle("post rst1", 1'b1, 1'b0, 16'h0);

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            logic        r_rdy, r_rv;
            logic [15:0] r_pc;
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rv  = ($urandom_range(0, 19) == 0);
            r_pc  = 16'($urandom);
            model_cycle($sformatf("rnd%0d", n), r_rdy, r_rv, r_pc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
